// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM: IF, ID, EX, (MEM), WB with decoded datapath strobes.
// Optional ILLEGAL_INSTR_EN adds an illegal output and a HALT state for unsupported instructions.
module multicycle_ctrl #(
    parameter int RET_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             Zero,
    output logic [31:0]      instr_q,
    output logic             PCSrc,
    output logic             ALUSrc,
    output logic             RegWrite,
    output logic             MemToReg,
    output logic [3:0]       ALUCtrl,
    output logic             loadPC,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [RET_W-1:0] retired
`ifdef ILLEGAL_INSTR_EN
    ,
    output logic             illegal
`endif
);

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
`ifdef ILLEGAL_INSTR_EN
    localparam logic [2:0] S_HALT = 3'd5;
`endif

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STOR = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       zero_q;
    logic       is_r;
    logic       is_i;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic [3:0] alu_dec;

    // funct7[5] only distinguishes SUB for register ops; for immediates it is part of the constant except on shifts.
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic f7b5, input logic reg_op);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (reg_op && f7b5) ? ALU_SUB : ALU_ADD;
            3'b111:  op = ALU_AND;
            3'b110:  op = ALU_OR;
            3'b100:  op = ALU_XOR;
            3'b010:  op = ALU_SLT;
            3'b001:  op = ALU_SLL;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    always_comb begin
        is_r   = (instr_q[6:0] == OP_R)    && (instr_q[14:12] != 3'b011);
        is_i   = (instr_q[6:0] == OP_I)    && (instr_q[14:12] != 3'b011);
        is_lw  = (instr_q[6:0] == OP_LOAD) && (instr_q[14:12] == 3'b010);
        is_sw  = (instr_q[6:0] == OP_STOR) && (instr_q[14:12] == 3'b010);
        is_beq = (instr_q[6:0] == OP_BR)   && (instr_q[14:12] == 3'b000);
        if (is_r || is_i)
            alu_dec = alu_op(instr_q[14:12], instr_q[30], is_r);
        else if (is_lw || is_sw)
            alu_dec = ALU_ADD;
        else if (is_beq)
            alu_dec = ALU_SUB;
        else
            alu_dec = 4'b0000;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IF:  state_nxt = S_ID;
`ifdef ILLEGAL_INSTR_EN
            S_ID:  state_nxt = (is_r || is_i || is_lw || is_sw || is_beq) ? S_EX : S_HALT;
            S_HALT: state_nxt = S_HALT;
`else
            S_ID:  state_nxt = S_EX;
`endif
            S_EX:  state_nxt = (is_lw || is_sw) ? S_MEM : S_WB;
            S_MEM: state_nxt = S_WB;
            S_WB:  state_nxt = S_IF;
            default: state_nxt = S_IF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IF;
            instr_q <= 32'd0;
            zero_q  <= 1'b0;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IF)
                instr_q <= instr;
            if (state == S_EX)
                zero_q <= Zero;
            if (state == S_WB)
                retired <= retired + RET_W'(1);
        end
    end

    // Strobes are pure functions of state and the latched instruction, so reset clears them at once.
    always_comb begin
        ALUCtrl  = 4'b0000;
        ALUSrc   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        MemToReg = 1'b0;
        loadPC   = 1'b0;
        PCSrc    = 1'b0;
        if (state == S_EX || state == S_MEM || state == S_WB) begin
            ALUCtrl = alu_dec;
            ALUSrc  = is_i || is_lw || is_sw;
        end
        if (state == S_MEM) begin
            MemRead  = is_lw;
            MemWrite = is_sw;
        end
        if (state == S_WB) begin
            RegWrite = is_r || is_i || is_lw;
            MemToReg = is_lw;
            loadPC   = 1'b1;
            PCSrc    = is_beq && zero_q;
        end
    end

`ifdef ILLEGAL_INSTR_EN
    assign illegal = (state == S_HALT);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues expected strobe events, a negedge monitor checks them.
module tb_multicycle_ctrl;

    localparam int RET_W = 32;

    logic             clk;
    logic             rst;
    logic [31:0]      instr;
    logic             Zero;
    logic [31:0]      instr_q;
    logic             PCSrc;
    logic             ALUSrc;
    logic             RegWrite;
    logic             MemToReg;
    logic [3:0]       ALUCtrl;
    logic             loadPC;
    logic             MemRead;
    logic             MemWrite;
    logic [RET_W-1:0] retired;
`ifdef ILLEGAL_INSTR_EN
    logic             illegal;
`endif

    multicycle_ctrl #(.RET_W(RET_W)) dut (
        .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .instr_q(instr_q),
        .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .ALUCtrl(ALUCtrl), .loadPC(loadPC), .MemRead(MemRead), .MemWrite(MemWrite),
        .retired(retired)
`ifdef ILLEGAL_INSTR_EN
        , .illegal(illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // strb bit order: MemRead, MemWrite, RegWrite, MemToReg, loadPC, PCSrc
    typedef struct {
        int          cyc;
        logic [31:0] iq;
        logic [5:0]  strb;
        logic        alusrc;
        logic [3:0]  aluc;
        logic [31:0] ret;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc;
    int  start_cyc;
    int  ret_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        logic [5:0] s;
        ev_t e;
        s = {MemRead, MemWrite, RegWrite, MemToReg, loadPC, PCSrc};
        if (!rst && s != 6'd0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: cycle %0d strb=%b, expected none", cyc + 1, s);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc + 1 || e.iq !== instr_q || e.strb !== s || e.alusrc !== ALUSrc ||
                    e.aluc !== ALUCtrl || e.ret !== retired) begin
                    errors++;
                    $display("FAIL event: got cyc=%0d iq=%h strb=%b src=%b alu=%b ret=%0d, expected cyc=%0d iq=%h strb=%b src=%b alu=%b ret=%0d",
                             cyc + 1, instr_q, s, ALUSrc, ALUCtrl, retired,
                             e.cyc, e.iq, e.strb, e.alusrc, e.aluc, e.ret);
                end
            end
        end
    end

    function automatic ev_t mk(input int c, input logic [31:0] w, input logic [5:0] s,
                               input logic src, input logic [3:0] a, input int r);
        ev_t e;
        e.cyc = c; e.iq = w; e.strb = s; e.alusrc = src; e.aluc = a; e.ret = r;
        return e;
    endfunction

    // kind: 0 = R/I-ALU, 1 = LW, 2 = SW, 3 = BEQ, 4 = unsupported (runs as NOP)
    task automatic issue(input logic [31:0] w, input int kind, input logic [3:0] a,
                         input logic src, input logic zx);
        int lat;
        lat = (kind == 1 || kind == 2) ? 5 : 4;
        case (kind)
            0: exp_q.push_back(mk(start_cyc + 3, w, 6'b001010, src, a, ret_cnt));
            1: begin
                exp_q.push_back(mk(start_cyc + 3, w, 6'b100000, 1'b1, 4'b0010, ret_cnt));
                exp_q.push_back(mk(start_cyc + 4, w, 6'b001110, 1'b1, 4'b0010, ret_cnt));
            end
            2: begin
                exp_q.push_back(mk(start_cyc + 3, w, 6'b010000, 1'b1, 4'b0010, ret_cnt));
                exp_q.push_back(mk(start_cyc + 4, w, 6'b000010, 1'b1, 4'b0010, ret_cnt));
            end
            3: exp_q.push_back(mk(start_cyc + 3, w, {5'b00001, zx}, 1'b0, 4'b0110, ret_cnt));
            default: exp_q.push_back(mk(start_cyc + 3, w, 6'b000010, 1'b0, 4'b0000, ret_cnt));
        endcase
        instr = w;
        repeat (2) @(posedge clk);
        #1 Zero = zx;
        @(posedge clk);
        #1 Zero = ~zx;
        repeat (lat - 3) @(posedge clk);
        #1;
        start_cyc += lat;
        ret_cnt++;
    endtask

    initial begin
        rst = 1'b1; instr = 32'd0; Zero = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_strobes", {26'd0, MemRead, MemWrite, RegWrite, MemToReg, loadPC, PCSrc}, 32'd0);
        check("rst_aluctrl", {27'd0, ALUSrc, ALUCtrl}, 32'd0);
        check("rst_instr_q", instr_q, 32'd0);
        check("rst_retired", retired, 32'd0);

        // sw aborted by reset in the middle of its MEM cycle
        rst = 1'b0;
        instr = 32'h00512623;
        repeat (3) @(posedge clk);
        #1 check("sw_mem_write", {31'd0, MemWrite}, 32'd1);
        #1 rst = 1'b1;
        #1 check("abort_memwrite", {31'd0, MemWrite}, 32'd0);
        check("abort_instr_q", instr_q, 32'd0);
        check("abort_retired", retired, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start_cyc = 1;
        ret_cnt = 0;

        issue(32'h00512623, 2, 4'b0010, 1'b1, 1'b0);  // sw re-fetched
        issue(32'h002081B3, 0, 4'b0010, 1'b0, 1'b0);  // add
        issue(32'h00812283, 1, 4'b0010, 1'b1, 1'b0);  // lw
        issue(32'h00208463, 3, 4'b0110, 1'b0, 1'b1);  // beq taken
        issue(32'h00208463, 3, 4'b0110, 1'b0, 1'b0);  // beq not taken, Zero=1 in WB
        issue(32'h402081B3, 0, 4'b0110, 1'b0, 1'b0);  // sub
        issue(32'h4020D1B3, 0, 4'b1010, 1'b0, 1'b0);  // sra
        issue(32'h0020C1B3, 0, 4'b1101, 1'b0, 1'b0);  // xor
        issue(32'h0020A1B3, 0, 4'b0111, 1'b0, 1'b0);  // slt
        issue(32'h00500093, 0, 4'b0010, 1'b1, 1'b0);  // addi
        issue(32'h4030D093, 0, 4'b1010, 1'b1, 1'b0);  // srai
        issue(32'h0070F093, 0, 4'b0000, 1'b1, 1'b0);  // andi
        check("retired_mid", retired, 32'(ret_cnt));

`ifdef ILLEGAL_INSTR_EN
        instr = 32'h0000007F;
        repeat (2) @(posedge clk);
        #1 check("illegal_set", {31'd0, illegal}, 32'd1);
        repeat (6) @(posedge clk);
        #1 check("illegal_held", {31'd0, illegal}, 32'd1);
        check("illegal_retired", retired, 32'(ret_cnt));
`else
        issue(32'h0000007F, 4, 4'b0000, 1'b0, 1'b0);  // unsupported opcode
        issue(32'h0020B1B3, 4, 4'b0000, 1'b0, 1'b0);  // sltu is not supported
        check("nop_retired", retired, 32'(ret_cnt));
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: RET_W, 32, width of retired-instruction counter.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 instr  in  32  instruction word from instruction ROM, sampled in IF.
REQ-006 Zero  in  1  ALU zero flag from datapath.
REQ-007 instr_q  out  32  latched instruction register, drives datapath instr.
REQ-008 PCSrc  out  1  select branch target on PC load.
REQ-009 ALUSrc  out  1  1 = immediate operand.
REQ-010 RegWrite  out  1  register-file write strobe.
REQ-011 MemToReg  out  1  1 = write back memory data.
REQ-012 ALUCtrl  out  4  ALU operation code.
REQ-013 loadPC  out  1  one-cycle PC update strobe.
REQ-014 MemRead / MemWrite  out  1 each  data-memory strobes.
REQ-015 retired  out  RET_W  count of completed instructions.

Function
REQ-016 FSM states: IF, ID, EX, MEM, WB, HALT; one state per cycle.
REQ-017 Transitions: IF->ID; ID->EX; EX->MEM for LW/SW, else EX->WB; MEM->WB; WB->IF.
REQ-018 Latency: R, I-ALU, BEQ, NOP = 4 cycles; LW, SW = 5 cycles.
REQ-019 instr_q loads instr on the IF->ID edge only; held constant through WB.
REQ-020 Supported: opcode 0110011 (add, sub, and, or, xor, slt, sll, srl, sra), 0010011 (addi, andi, ori, xori, slti, slli, srli, srai), 0000011 funct3 010 (LW), 0100011 funct3 010 (SW), 1100011 funct3 000 (BEQ).
REQ-021 ALUCtrl encoding: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SRL 1000, SLL 1001, SRA 1010, XOR 1101; LW/SW use ADD, BEQ uses SUB; funct7[5] selects SUB/SRA.
REQ-022 ALUCtrl and ALUSrc: decoded from instr_q and valid from EX through WB; 0 in IF/ID.
REQ-023 ALUSrc = 1 for I-ALU, LW, SW; 0 otherwise.
REQ-024 Zero is registered on the EX->next edge; the registered value is used, never live Zero.
REQ-025 MemRead = 1 in MEM for LW only; MemWrite = 1 in MEM for SW only, exactly one cycle.
REQ-026 RegWrite = 1 in WB only, for R, I-ALU, LW; MemToReg = 1 in WB only, for LW.
REQ-027 loadPC = 1 in WB only, every instruction; PCSrc = 1 in WB iff BEQ and registered Zero = 1.
REQ-028 retired increments by 1 on the WB->IF edge; wraps from 2^RET_W-1 to 0.
REQ-029 All strobes are 0 in every state not listed for them.

Reset
REQ-030 rst = 1 forces state IF, instr_q 0, registered Zero 0, retired 0, and all control outputs 0 immediately, without waiting for a clock edge.
REQ-031 Reset mid-instruction aborts it: no RegWrite, MemWrite or loadPC is issued; retired is not incremented.
REQ-032 The first IF occurs on the first rising edge after rst deasserts.

Configuration
REQ-033 Macro ILLEGAL_INSTR_EN defined: output illegal (1 bit) is added; an unsupported opcode/funct3 in ID moves the FSM to HALT, which sets illegal = 1 and drives all strobes 0 until rst.
REQ-034 ILLEGAL_INSTR_EN undefined: there is no illegal port and no HALT state; an unsupported instruction runs IF, ID, EX, WB as a NOP, with loadPC = 1 and PCSrc = 0 in WB, no writes, and retired incremented.

Verification
REQ-035 0x002081B3 (add x3,x1,x2) -> cycle 4 = WB: RegWrite = 1, loadPC = 1, ALUCtrl = 0010, ALUSrc = 0, PCSrc = 0; retired = 1.
REQ-036 0x00812283 (lw x5,8(x2)) -> cycle 4 MemRead = 1; cycle 5 RegWrite = MemToReg = loadPC = 1; ALUSrc = 1; ALUCtrl = 0010.
REQ-037 0x00512623 (sw x5,12(x2)) -> MemWrite = 1 in cycle 4 only; RegWrite = 0 throughout; loadPC = 1 in cycle 5.
REQ-038 0x00208463 (beq x1,x2,+8): Zero = 1 in EX -> WB has PCSrc = 1, loadPC = 1, ALUCtrl = 0110; Zero = 0 in EX (and 1 during WB) -> PCSrc = 0.
REQ-039 0x0000007F -> with ILLEGAL_INSTR_EN, illegal = 1 from cycle 3, loadPC never asserts, retired stays 0; without it, 4-cycle NOP and retired = 1.
REQ-040 rst asserted mid-MEM of sw -> MemWrite drops to 0 before the next edge, state = IF, retired = 0, and sw is re-fetched after release.
